// File: rtl/cpu_core.sv
// Multi-cycle register-file CPU: accept -> read -> execute -> write-back.
// One three-operand ALU instruction in flight at a time; NREGS x WIDTH register file.
module cpu_core #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int RA    = $clog2(NREGS),
    localparam int IW    = 3*RA + 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [IW-1:0]          instr,
    input  logic [WIDTH-1:0]       imm,
    output logic [NREGS*WIDTH-1:0] regs,
    output logic                   wb_valid,
    output logic [RA-1:0]          wb_addr,
    output logic [WIDTH-1:0]       wb_data,
    output logic                   zero,
    output logic                   carry,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                           OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SHL = 3'b101,
                           OP_SHR = 3'b110;

    state_t                        state, state_nxt;
    logic [NREGS-1:0][WIDTH-1:0]   rf;
    logic [IW-1:0]                 ir;
    logic [WIDTH-1:0]              imm_q, op_a, op_b, res_q, res_nxt;
    logic                          c_q, c_nxt;
    logic [WIDTH:0]                sum;
    logic [RA-1:0]                 dst, src_a, src_b;
    logic [2:0]                    opc;
    logic                          accept;

    assign {dst, src_a, src_b, opc} = ir;
    assign accept = instr_valid && instr_ready;
    assign regs   = rf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE) && cs;
        busy        = (state != IDLE);
    end

    // ALU works on operands captured in READ, so dst aliasing a source is safe.
    always_comb begin
        res_nxt = '0;
        c_nxt   = 1'b0;
        sum     = '0;
        case (opc)
            OP_ADD: begin
                sum     = {1'b0, op_a} + {1'b0, op_b};
                res_nxt = sum[WIDTH-1:0];
                c_nxt   = sum[WIDTH];
            end
            OP_SUB: begin
                res_nxt = op_a - op_b;
                c_nxt   = (op_a < op_b);
            end
            OP_AND: res_nxt = op_a & op_b;
            OP_OR:  res_nxt = op_a | op_b;
            OP_XOR: res_nxt = op_a ^ op_b;
            OP_SHL: begin
                res_nxt = {op_a[WIDTH-2:0], 1'b0};
                c_nxt   = op_a[WIDTH-1];
            end
            OP_SHR: begin
                res_nxt = {1'b0, op_a[WIDTH-1:1]};
                c_nxt   = op_a[0];
            end
            default: res_nxt = imm_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf       <= '0;
            ir       <= '0;
            imm_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res_q    <= '0;
            c_q      <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    ir    <= instr;
                    imm_q <= imm;
                end
                READ: begin
                    op_a <= rf[src_a];
                    op_b <= rf[src_b];
                end
                EXEC: begin
                    res_q <= res_nxt;
                    c_q   <= c_nxt;
                end
                default: begin
                    rf[dst]  <= res_q;
                    wb_valid <= 1'b1;
                    wb_addr  <= dst;
                    wb_data  <= res_q;
                    zero     <= (res_q == '0);
                    carry    <= c_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed spec sequences plus randomized programs checked
// against an arithmetic model of the register file and flags.
module tb_cpu_core;

    localparam int W = 8, N = 4, RA = 2, IW = 3*RA + 3;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SHL = 3'd5, SHR = 3'd6, LDI = 3'd7;

    logic            clk = 1'b0;
    logic            reset, cs, instr_valid, instr_ready;
    logic [IW-1:0]   instr;
    logic [W-1:0]    imm, wb_data;
    logic [N*W-1:0]  regs;
    logic            wb_valid, zero, carry, busy;
    logic [RA-1:0]   wb_addr;

    int checks = 0, errors = 0;
    logic [W-1:0] mreg [N];
    logic         mz, mc;

    cpu_core #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .reset(reset), .cs(cs), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .imm(imm), .regs(regs),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .zero(zero), .carry(carry), .busy(busy)
    );

    always #5 clk = ~clk;

    // Program word: {dst, srcA, srcB, opcode, imm}
    function automatic logic [16:0] mk(input int d, sa, sb, input logic [2:0] op, input int im);
        return {d[1:0], sa[1:0], sb[1:0], op, im[7:0]};
    endfunction

    function automatic void alu(input logic [2:0] op, input logic [W-1:0] a, b, im,
                                output logic [W-1:0] r, output logic c);
        int unsigned ai, bi, s, m;
        ai = a; bi = b; m = 1 << W;
        c = 1'b0;
        case (op)
            3'd0: begin s = ai + bi; r = W'(s % m); c = (s >= m); end
            3'd1: begin r = W'((ai + m - bi) % m); c = (ai < bi); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = W'((ai * 2) % m); c = (ai >= m / 2); end
            3'd6: begin r = W'(ai / 2); c = (ai % 2 == 1); end
            default: r = im;
        endcase
    endfunction

    task automatic model_exec(input logic [16:0] p, output logic [W-1:0] r);
        logic c;
        alu(p[10:8], mreg[p[14:13]], mreg[p[12:11]], p[7:0], r, c);
        mreg[p[16:15]] = r;
        mz = (r == '0);
        mc = c;
    endtask

    function automatic logic [N*W-1:0] mflat();
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = mreg[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mreg[i] = '0;
        mz = 1'b0; mc = 1'b0;
    endtask

    // Drives one instruction from a negedge; returns accept-to-wb_valid latency in
    // cycles (-1 if never seen) and whether busy/ready/wb_valid behaved meanwhile.
    task automatic issue(input logic [16:0] p, input bit drop_cs, output int lat, output bit ok);
        int n;
        cs = 1'b1; instr_valid = 1'b1; instr = p[16:8]; imm = p[7:0];
        lat = -1; ok = 1'b1; n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!instr_ready) begin instr_valid = 1'b0; ok = 1'b0; return; end
        @(negedge clk);
        instr_valid = 1'b0; instr = IW'($urandom); imm = W'($urandom);
        if (drop_cs) cs = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (wb_valid === 1'b1) begin
                lat = k;
                if (busy !== 1'b0 || instr_ready !== cs) ok = 1'b0;
                break;
            end
            if (busy !== 1'b1 || instr_ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        if (wb_valid !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cs = 1'b0; instr_valid = 1'b0; instr = '0; imm = '0;
        model_reset();
        #1;
        checks++;
        if ({regs, zero, carry, wb_valid, wb_addr, wb_data, busy, instr_ready} !== '0) begin
            errors++;
            $display("FAIL reset_cs0 got regs=%h z=%b c=%b wbv=%b wa=%0d wd=%h busy=%b rdy=%b want all zero",
                     regs, zero, carry, wb_valid, wb_addr, wb_data, busy, instr_ready);
        end
        cs = 1'b1; #1;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_cs1 got rdy=%b busy=%b want rdy=1 busy=0", instr_ready, busy);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ldi_add();
        logic [16:0] prog [3];
        logic [W-1:0] ew;
        int lat; bit ok;
        prog[0] = mk(1, 0, 0, LDI, 8'h05);
        prog[1] = mk(2, 0, 0, LDI, 8'h03);
        prog[2] = mk(3, 1, 2, ADD, 0);
        foreach (prog[i]) begin
            issue(prog[i], 1'b0, lat, ok);
            model_exec(prog[i], ew);
            checks++;
            if (lat !== 4 || !ok || wb_addr !== prog[i][16:15] || wb_data !== ew ||
                zero !== mz || carry !== mc || regs !== mflat()) begin
                errors++;
                $display("FAIL ldi_add[%0d] got lat=%0d hs=%0d wa=%0d wd=%h z=%b c=%b regs=%h want lat=4 wa=%0d wd=%h z=%b c=%b regs=%h",
                         i, lat, ok, wb_addr, wb_data, zero, carry, regs, prog[i][16:15], ew, mz, mc, mflat());
            end
        end
        checks++;
        if (regs[3*W +: W] !== 8'h08 || wb_addr !== 2'd3 || zero !== 1'b0 || carry !== 1'b0) begin
            errors++;
            $display("FAIL add_const got r3=%h wa=%0d z=%b c=%b want r3=08 wa=3 z=0 c=0",
                     regs[3*W +: W], wb_addr, zero, carry);
        end
    endtask

    task automatic test_overflow_borrow();
        logic [16:0] prog [6];
        logic [W-1:0] ew;
        int lat; bit ok;
        prog[0] = mk(1, 0, 0, LDI, 8'hFF);
        prog[1] = mk(2, 0, 0, LDI, 8'h01);
        prog[2] = mk(0, 1, 2, ADD, 0);
        prog[3] = mk(1, 0, 0, LDI, 8'h03);
        prog[4] = mk(2, 0, 0, LDI, 8'h05);
        prog[5] = mk(0, 1, 2, SUB, 0);
        foreach (prog[i]) begin
            issue(prog[i], 1'b0, lat, ok);
            model_exec(prog[i], ew);
            checks++;
            if (lat !== 4 || !ok || wb_addr !== prog[i][16:15] || wb_data !== ew ||
                zero !== mz || carry !== mc || regs !== mflat()) begin
                errors++;
                $display("FAIL ovf_borrow[%0d] got lat=%0d hs=%0d wa=%0d wd=%h z=%b c=%b regs=%h want lat=4 wa=%0d wd=%h z=%b c=%b regs=%h",
                         i, lat, ok, wb_addr, wb_data, zero, carry, regs, prog[i][16:15], ew, mz, mc, mflat());
            end
            if (i == 2) begin
                checks++;
                if (regs[W-1:0] !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin
                    errors++;
                    $display("FAIL add_ovf got r0=%h z=%b c=%b want r0=00 z=1 c=1", regs[W-1:0], zero, carry);
                end
            end
        end
        checks++;
        if (regs[W-1:0] !== 8'hFE || zero !== 1'b0 || carry !== 1'b1) begin
            errors++;
            $display("FAIL sub_borrow got r0=%h z=%b c=%b want r0=fe z=0 c=1", regs[W-1:0], zero, carry);
        end
    endtask

    task automatic test_shift_alias();
        logic [16:0] prog [3];
        logic [W-1:0] ew;
        int lat; bit ok;
        prog[0] = mk(1, 0, 0, LDI, 8'h81);
        prog[1] = mk(1, 1, 3, SHL, 0);
        prog[2] = mk(1, 1, 0, SHR, 0);
        foreach (prog[i]) begin
            issue(prog[i], 1'b0, lat, ok);
            model_exec(prog[i], ew);
            checks++;
            if (lat !== 4 || !ok || wb_data !== ew || zero !== mz || carry !== mc || regs !== mflat()) begin
                errors++;
                $display("FAIL shift[%0d] got lat=%0d hs=%0d wd=%h z=%b c=%b regs=%h want wd=%h z=%b c=%b regs=%h",
                         i, lat, ok, wb_data, zero, carry, regs, ew, mz, mc, mflat());
            end
            if (i == 1) begin
                checks++;
                if (regs[W +: W] !== 8'h02 || carry !== 1'b1) begin
                    errors++;
                    $display("FAIL shl_const got r1=%h c=%b want r1=02 c=1", regs[W +: W], carry);
                end
            end
        end
        checks++;
        if (regs[W +: W] !== 8'h01 || carry !== 1'b0) begin
            errors++;
            $display("FAIL shr_const got r1=%h c=%b want r1=01 c=0", regs[W +: W], carry);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] prog [3];
        logic [W-1:0] ew;
        int idx, last, bad_gap, bad_rdy;
        bit acc;
        foreach (prog[i]) prog[i] = mk($urandom_range(3), $urandom_range(3), $urandom_range(3),
                                       3'($urandom), $urandom);
        idx = 0; last = -1; bad_gap = 0; bad_rdy = 0;
        cs = 1'b1; instr_valid = 1'b1; instr = prog[0][16:8]; imm = prog[0][7:0];
        for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
            acc = 1'b0;
            if (instr_ready === 1'b1) begin
                if (last >= 0 && cyc - last != 4) bad_gap++;
                last = cyc; acc = 1'b1;
                model_exec(prog[idx], ew);
                idx++;
            end
            if (instr_ready !== !busy) bad_rdy++;
            @(negedge clk);
            if (acc) begin
                if (idx < 3) begin instr = prog[idx][16:8]; imm = prog[idx][7:0]; end
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (idx !== 3 || bad_gap !== 0 || bad_rdy !== 0) begin
            errors++;
            $display("FAIL b2b_handshake got accepts=%0d bad_gaps=%0d rdy_busy_bad=%0d want 3 0 0", idx, bad_gap, bad_rdy);
        end
        checks++;
        if (regs !== mflat() || zero !== mz || carry !== mc) begin
            errors++;
            $display("FAIL b2b_result got regs=%h z=%b c=%b want regs=%h z=%b c=%b", regs, zero, carry, mflat(), mz, mc);
        end
    endtask

    task automatic test_cs_gate();
        logic [16:0] p;
        logic [W-1:0] ew;
        int lat, bad; bit ok;
        bad = 0;
        cs = 1'b0; instr_valid = 1'b1; instr = mk(2, 0, 0, LDI, 8'h5A) >> 8; imm = 8'h5A;
        repeat (10) begin
            @(negedge clk);
            if (instr_ready !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) bad++;
        end
        instr_valid = 1'b0;
        checks++;
        if (bad !== 0 || regs !== mflat()) begin
            errors++;
            $display("FAIL cs_block got bad_cycles=%0d regs=%h want 0 regs=%h", bad, regs, mflat());
        end
        p = mk(2, 1, 3, ADD, 0);
        issue(p, 1'b1, lat, ok);
        model_exec(p, ew);
        checks++;
        if (lat !== 4 || !ok || wb_data !== ew || regs !== mflat() || zero !== mz || carry !== mc) begin
            errors++;
            $display("FAIL cs_drop got lat=%0d hs=%0d wd=%h regs=%h want lat=4 wd=%h regs=%h",
                     lat, ok, wb_data, regs, ew, mflat());
        end
        cs = 1'b1;
    endtask

    task automatic test_random();
        logic [16:0] p;
        logic [W-1:0] ew;
        int lat; bit ok;
        for (int i = 0; i < 40; i++) begin
            p = mk($urandom_range(3), $urandom_range(3), $urandom_range(3), 3'($urandom), $urandom);
            issue(p, 1'b0, lat, ok);
            model_exec(p, ew);
            checks++;
            if (lat !== 4 || !ok || wb_addr !== p[16:15] || wb_data !== ew ||
                zero !== mz || carry !== mc || regs !== mflat()) begin
                errors++;
                $display("FAIL rand[%0d] op=%0d got lat=%0d hs=%0d wa=%0d wd=%h z=%b c=%b regs=%h want wa=%0d wd=%h z=%b c=%b regs=%h",
                         i, p[10:8], lat, ok, wb_addr, wb_data, zero, carry, regs, p[16:15], ew, mz, mc, mflat());
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [16:0] prog [3];
        logic [W-1:0] ew;
        int lat, n, bad; bit ok;
        prog[0] = mk(1, 0, 0, LDI, 8'h85);
        prog[1] = mk(2, 0, 0, LDI, 8'h80);
        prog[2] = mk(0, 1, 2, ADD, 0);
        foreach (prog[i]) begin
            issue(prog[i], 1'b0, lat, ok);
            model_exec(prog[i], ew);
        end
        checks++;
        if (regs !== mflat() || carry !== 1'b1 || wb_data !== 8'h05) begin
            errors++;
            $display("FAIL pre_reset got regs=%h c=%b wd=%h want regs=%h c=1 wd=05", regs, carry, wb_data, mflat());
        end
        cs = 1'b1; instr_valid = 1'b1; instr = mk(3, 1, 2, ADD, 0) >> 8; imm = '0;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({regs, zero, carry, wb_valid, wb_addr, wb_data, busy} !== '0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got regs=%h z=%b c=%b wbv=%b wa=%0d wd=%h busy=%b rdy=%b want zeros rdy=1",
                     regs, zero, carry, wb_valid, wb_addr, wb_data, busy, instr_ready);
        end
        cs = 1'b0; #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_cs got rdy=%b want 0", instr_ready);
        end
        cs = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (wb_valid !== 1'b0 || busy !== 1'b0 || regs !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort got bad_cycles=%0d want 0", bad);
        end
        prog[0] = mk(3, 0, 0, LDI, 8'hAA);
        issue(prog[0], 1'b0, lat, ok);
        model_exec(prog[0], ew);
        checks++;
        if (lat !== 4 || !ok || regs[3*W +: W] !== 8'hAA || wb_addr !== 2'd3 || regs !== mflat()) begin
            errors++;
            $display("FAIL post_reset_ldi got lat=%0d hs=%0d r3=%h wa=%0d regs=%h want lat=4 r3=aa wa=3 regs=%h",
                     lat, ok, regs[3*W +: W], wb_addr, regs, mflat());
        end
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_overflow_borrow();
        test_shift_alias();
        test_back_to_back();
        test_cs_gate();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
